// File: rtl/stage_load_sequencer.sv
// Stage load sequencer: turns phase-code entries into one-shot
// pipeline register load pulses and tracks occupancy/retirement.
module stage_load_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stage,
  input  logic        issue,
  input  logic        stall,
  input  logic        flush,
  output logic        ld_if_id,
  output logic        ld_id_ex,
  output logic        ld_ex_wb,
  output logic [2:0]  valid,
  output logic [15:0] retired_cnt,
  output logic        stage_err
);

  localparam logic [1:0] PH_IF_ID = 2'd0;
  localparam logic [1:0] PH_ID_EX = 2'd1;
  localparam logic [1:0] PH_EX_WB = 2'd2;
  localparam logic [1:0] PH_ILL   = 2'd3;

  logic [1:0]  stage_q, stage_d;
  logic        pend_v_q, pend_v_d;
  logic [1:0]  pend_c_q, pend_c_d;
  logic [2:0]  ld_q, ld_d;
  logic [2:0]  valid_q, valid_d;
  logic [15:0] ret_q, ret_d;
  logic        err_q, err_d;

  logic        legal;
  logic        entry;
  logic        cand_v;
  logic [1:0]  cand_c;
  logic        fire;

  // A fresh entry always supersedes whatever was still pending.
  always_comb begin
    legal  = (stage != PH_ILL);
    entry  = legal && (stage != stage_q);
    cand_v = entry || pend_v_q;
    cand_c = entry ? stage : pend_c_q;
    fire   = cand_v && !stall && !flush
             && (cand_c == stage);
  end

  always_comb begin
    stage_d  = legal ? stage : stage_q;
    err_d    = err_q || !legal;
    pend_v_d = cand_v && stall && !flush;
    pend_c_d = pend_v_d ? cand_c : pend_c_q;
  end

  always_comb begin
    ld_d    = 3'b000;
    valid_d = valid_q;
    ret_d   = ret_q;
    if (flush) begin
      valid_d = 3'b000;
    end else if (fire) begin
      unique case (1'b1)
        cand_c == PH_IF_ID: begin
          ld_d       = 3'b001;
          valid_d[0] = issue;
        end
        cand_c == PH_ID_EX: begin
          ld_d       = 3'b010;
          valid_d[1] = valid_q[0];
        end
        cand_c == PH_EX_WB: begin
          ld_d       = 3'b100;
          valid_d[2] = valid_q[1];
          if (valid_q[1]) ret_d = ret_q + 16'd1;
        end
        default: ld_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q  <= PH_ILL;
      pend_v_q <= 1'b0;
      pend_c_q <= PH_IF_ID;
      ld_q     <= 3'b000;
      valid_q  <= 3'b000;
      ret_q    <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      pend_v_q <= pend_v_d;
      pend_c_q <= pend_c_d;
      ld_q     <= ld_d;
      valid_q  <= valid_d;
      ret_q    <= ret_d;
      err_q    <= err_d;
    end
  end

  assign ld_if_id    = ld_q[0];
  assign ld_id_ex    = ld_q[1];
  assign ld_ex_wb    = ld_q[2];
  assign valid       = valid_q;
  assign retired_cnt = ret_q;
  assign stage_err   = err_q;

endmodule

// File: doc/stage_load_sequencer.md
STAGE_LOAD_SEQUENCER -- requirements
Module: stage_load_sequencer

Interface
REQ-001 SHALL have clk, input, 1, clock; all state updates on posedge clk.
REQ-002 SHALL have rst, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have stage, input, 2, phase code from the phase controller: 0=IF_ID, 1=ID_EX, 2=EX_WB, 3=illegal.
REQ-004 SHALL have issue, input, 1, new instruction available; sampled in the entry cycle of phase 0.
REQ-005 SHALL have stall, input, 1, holds the pipeline; suppresses load pulses.
REQ-006 SHALL have flush, input, 1, synchronous pipeline clear.
REQ-007 SHALL have ld_if_id, output, 1, one-cycle load pulse for the IF/ID register.
REQ-008 SHALL have ld_id_ex, output, 1, one-cycle load pulse for the ID/EX register.
REQ-009 SHALL have ld_ex_wb, output, 1, one-cycle load pulse for the EX/WB register.
REQ-010 SHALL have valid, output, 3, occupancy bits: [0]=IF/ID, [1]=ID/EX, [2]=EX/WB.
REQ-011 SHALL have retired_cnt, output, 16, count of valid instructions entering writeback.
REQ-012 SHALL have stage_err, output, 1, sticky flag for illegal phase code.

Function
REQ-013 SHALL register stage into stage_q each cycle when stage is legal (0..2); stage_q SHALL hold when stage==3.
REQ-014 SHALL detect an entry in cycle N when stage is legal and stage != stage_q.
REQ-015 SHALL register an entry event as pending; pending SHALL hold the phase code of the most recent entry, and a newer entry SHALL replace an older pending one.
REQ-016 SHALL fire a pending entry in the first cycle M (M>=N) with stall=0 and flush=0, provided stage still equals the pending code; otherwise the entry SHALL be dropped.
REQ-017 SHALL assert exactly one load pulse in cycle M+1, selected by the fired code: 0->ld_if_id, 1->ld_id_ex, 2->ld_ex_wb. Each pulse SHALL be high for one cycle only.
REQ-018 SHALL update valid on the same edge as the pulse: ld_if_id sets valid[0]=issue sampled in cycle M; ld_id_ex sets valid[1]=valid[0]; ld_ex_wb sets valid[2]=valid[1].
REQ-019 SHALL increment retired_cnt on the ld_ex_wb edge when valid[1]==1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-020 SHALL, when flush=1 in cycle F, clear valid to 3'b000 and clear pending at the end of cycle F, with no load pulse in cycle F+1. Flush SHALL take priority over a simultaneous entry, and a simultaneous entry SHALL be discarded.
REQ-021 SHALL, while stall=1, hold the valid bits and retired_cnt and assert no load pulses, while stage_q continues to track stage.
REQ-022 SHALL set stage_err on the edge after stage==3 is seen, and keep it set until reset; an illegal code SHALL create no entry.
REQ-023 SHALL keep load pulses mutually exclusive, with at most one pulse per cycle.

Reset
REQ-024 SHALL, on rst=0 and regardless of clk, drive the following: ld_* = 0, valid = 3'b000, retired_cnt = 0, stage_err = 0, pending cleared, stage_q = 2'b11 (sentinel).
REQ-025 SHALL treat the first legal stage after reset release as an entry, because of the sentinel in stage_q.
REQ-026 SHALL, when reset is asserted mid-operation, abort any pending or in-flight pulse immediately with no residual pulse after release.

Verification
REQ-027 SHALL cover this sequence: release reset with stage=0 and issue=1 -> ld_if_id=1 one cycle after release, then valid=3'b001.
REQ-028 SHALL cover this sequence: stage 0->1->2 with issue=1 and no stall -> pulses ld_if_id, ld_id_ex, ld_ex_wb in order, ending with valid=3'b111 and retired_cnt=1.
REQ-029 SHALL cover this sequence: stall=1 for 3 cycles during an entry to 1, then released with stage still 1 -> no pulse while stalled, and ld_id_ex exactly one cycle after stall falls.
REQ-030 SHALL cover this sequence: flush=1 in the same cycle as an entry to 2 with valid=3'b011 -> no ld_ex_wb, valid=3'b000, and retired_cnt unchanged.
REQ-031 SHALL cover this sequence: stage=3 for one cycle -> stage_err=1 with no pulse; the next legal code equal to stage_q produces no entry, and stage_err stays 1 until rst=0.
REQ-032 SHALL cover this sequence: preload retired_cnt to 0xFFFF through 65535 retirements, then one more retirement -> retired_cnt=0x0000.
